jtkcpu_pshpul: RTL and testbench
================================

JTKCPU_PSHPUL -- requirements
Module: jtkcpu_pshpul

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port cen, input, 1: clock enable; state advances only on clk edges with cen=1.
REQ-004 SHALL have port start, input, 1: begin a PSH/PUL sequence; sampled in IDLE only.
REQ-005 SHALL have port pull, input, 1: 1=PUL, 0=PSH; captured with start.
REQ-006 SHALL have port ussel, input, 1: 1=U stack, 0=S stack; captured with start.
REQ-007 SHALL have port mask, input, 8: postbyte register mask (b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 U/S, b7 PC); captured with start.
REQ-008 SHALL have port psh_sel, output, 8: one-hot current register select, fed to the register file.
REQ-009 SHALL have port psh_hilon, output, 1: 1=high byte, 0=low byte of current 16-bit register.
REQ-010 SHALL have port psh_ussel, output, 1: captured ussel.
REQ-011 SHALL have port pul_en, output, 1: pull byte strobe.
REQ-012 SHALL have port dec_us, output, 1: push byte strobe / stack decrement.
REQ-013 SHALL have port we, output, 1: memory write strobe, equal to dec_us.
REQ-014 SHALL have port busy, output, 1: high outside IDLE.
REQ-015 SHALL have port done, output, 1: one-cen-cycle completion pulse.
REQ-016 SHALL have port nbytes, output, 4: bytes transferred in the current/last sequence.

Function
REQ-017 SHALL implement states IDLE, XFER, DONE.
REQ-018 SHALL, in IDLE with cen=1 and start=1, capture pull/ussel/mask, clear nbytes, and enter XFER, or DONE if mask=0.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL, in XFER, select the highest remaining mask bit for push (PC first, CC last) and the lowest for pull (CC first, PC last).
REQ-021 SHALL drive psh_sel one-hot with the selected bit; psh_sel=0 in IDLE/DONE.
REQ-022 SHALL transfer one byte per cen cycle in XFER, with dec_us=we=1 for push and pul_en=1 for pull, else 0.
REQ-023 SHALL, for bits 4-7, transfer two bytes: push low (psh_hilon=0) then high; pull high (psh_hilon=1) then low; one byte for bits 0-3 with psh_hilon=0.
REQ-024 SHALL clear the selected mask bit after its last byte and increment nbytes per byte (maximum 12, no wrap).
REQ-025 SHALL enter DONE when the remaining mask is 0 after a byte, pulse done=1 for that one cen cycle, then return to IDLE.
REQ-026 SHALL hold all outputs and state while cen=0; strobes are qualified by state, not cen.

Reset
REQ-027 SHALL, with rst_n=0 at any time including mid-sequence, force IDLE, mask=0, psh_sel=0, psh_hilon=0, psh_ussel=0, pul_en=0, dec_us=0, we=0, busy=0, done=0, nbytes=0.

Configuration
REQ-028 SHALL, with JTKCPU_PSHPUL_WAIT_EN defined, add input mem_wait (1 bit); XFER holds state, byte index and nbytes while mem_wait=1 and keeps the strobes asserted.
REQ-029 SHALL, without JTKCPU_PSHPUL_WAIT_EN, omit mem_wait; no stall occurs.

Structure
REQ-030 SHALL place state encodings and mask bit-position constants (CC..PC) in shared package jtkcpu_pkg.
REQ-031 SHALL use one sub-module, jtkcpu_prio8, giving the one-hot highest or lowest set bit of an 8-bit vector by a direction input.

Verification
REQ-032 SHALL check push mask=0x81, ussel=0: PC low, PC high, CC over 3 cycles; dec_us=we=1; done on 3rd byte; nbytes=3.
REQ-033 SHALL check pull mask=0xFF, ussel=1: order CC,A,B,DP,X(h,l),Y(h,l),U(h,l),PC(h,l); 12 pul_en; nbytes=12; psh_ussel=1.
REQ-034 SHALL check mask=0x00 start -> done pulse next cen cycle, no strobes, nbytes=0.
REQ-035 SHALL check rst_n=0 after 2 bytes of mask=0x30 push -> all outputs zero; a subsequent start runs normally.
REQ-036 SHALL check cen toggling 1/0 during pull mask=0x06 -> 2 pul_en cycles, outputs frozen while cen=0; start during busy ignored.
REQ-037 SHALL check, with JTKCPU_PSHPUL_WAIT_EN, mem_wait=1 for 2 cycles on X high byte -> same psh_sel/psh_hilon held, nbytes unchanged.

Source files
------------

// File: rtl/jtkcpu_pkg.sv
// Shared constants for the PSH/PUL sequencer: FSM states, postbyte mask bit positions
// and a saturating byte-count increment.
package jtkcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } pshpul_st_e;

  localparam int unsigned BIT_CC = 0;
  localparam int unsigned BIT_A  = 1;
  localparam int unsigned BIT_B  = 2;
  localparam int unsigned BIT_DP = 3;
  localparam int unsigned BIT_X  = 4;
  localparam int unsigned BIT_Y  = 5;
  localparam int unsigned BIT_US = 6;
  localparam int unsigned BIT_PC = 7;

  // Registers whose mask bit selects a 16-bit (two byte) transfer
  localparam logic [7:0] WIDE_MASK = 8'((1 << BIT_X) | (1 << BIT_Y) | (1 << BIT_US) | (1 << BIT_PC));

  localparam logic [3:0] NBYTES_MAX = 4'd12;

  function automatic logic [3:0] nbytes_inc(input logic [3:0] n);
    return (n >= NBYTES_MAX) ? NBYTES_MAX : n + 4'd1;
  endfunction

endpackage

// File: rtl/jtkcpu_prio8.sv
// One-hot priority pick of an 8-bit vector: highest set bit when hi_i=1, lowest when hi_i=0.
// Purely combinational, zero latency, no flow control.
module jtkcpu_prio8 (
  input  logic [7:0] vec_i,
  input  logic       hi_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (hi_i) begin
      for (int i = 0; i < 8; i++) begin
        if (vec_i[i]) begin
          onehot_o    = '0;
          onehot_o[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (vec_i[i]) begin
          onehot_o    = '0;
          onehot_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// PSH/PUL byte sequencer: one register byte per cen cycle, strobes decoded from state.
// Optional JTKCPU_PSHPUL_WAIT_EN adds mem_wait, which stalls XFER with strobes held.
module jtkcpu_pshpul
  import jtkcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       start,
  input  logic       pull,
  input  logic       ussel,
  input  logic [7:0] mask,
`ifdef JTKCPU_PSHPUL_WAIT_EN
  input  logic       mem_wait,
`endif
  output logic [7:0] psh_sel,
  output logic       psh_hilon,
  output logic       psh_ussel,
  output logic       pul_en,
  output logic       dec_us,
  output logic       we,
  output logic       busy,
  output logic       done,
  output logic [3:0] nbytes
);

  pshpul_st_e state_q, state_d;
  logic       pull_q, pull_d;
  logic       us_q, us_d;
  logic [7:0] mask_q, mask_d;
  logic       idx_q, idx_d;
  logic [3:0] nbytes_q, nbytes_d;

  logic [7:0] sel;
  logic [7:0] remain;
  logic       wide;
  logic       xfer;
  logic       stall;

`ifdef JTKCPU_PSHPUL_WAIT_EN
  assign stall = mem_wait;
`else
  assign stall = 1'b0;
`endif

  // Push walks from PC down to CC, pull walks from CC up to PC
  jtkcpu_prio8 u_prio (
    .vec_i    (mask_q),
    .hi_i     (~pull_q),
    .onehot_o (sel)
  );

  assign wide   = |(sel & WIDE_MASK);
  assign remain = mask_q & ~sel;
  assign xfer   = (state_q == ST_XFER);

  always_comb begin
    state_d  = state_q;
    pull_d   = pull_q;
    us_d     = us_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    nbytes_d = nbytes_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pull_d   = pull;
          us_d     = ussel;
          mask_d   = mask;
          idx_d    = 1'b0;
          nbytes_d = '0;
          state_d  = (mask == 8'd0) ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        if (!stall) begin
          nbytes_d = nbytes_inc(nbytes_q);
          if (wide && !idx_q) begin
            idx_d = 1'b1;
          end else begin
            idx_d  = 1'b0;
            mask_d = remain;
            if (remain == 8'd0) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pull_q   <= 1'b0;
      us_q     <= 1'b0;
      mask_q   <= '0;
      idx_q    <= 1'b0;
      nbytes_q <= '0;
    end else if (cen) begin
      state_q  <= state_d;
      pull_q   <= pull_d;
      us_q     <= us_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      nbytes_q <= nbytes_d;
    end
  end

  // Push sends low then high, pull receives high then low
  assign psh_hilon = xfer & wide & (idx_q ^ pull_q);
  assign psh_sel   = xfer ? sel : 8'd0;
  assign psh_ussel = us_q;
  assign pul_en    = xfer & pull_q;
  assign dec_us    = xfer & ~pull_q;
  assign we        = dec_us;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign nbytes    = nbytes_q;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Bench for jtkcpu_pshpul: queue-based byte-order model checked every cycle plus directed literal cases.
module tb_jtkcpu_pshpul;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen, start, pull, ussel;
  logic [7:0] mask;
  logic       mem_wait;
  logic [7:0] psh_sel;
  logic       psh_hilon, psh_ussel, pul_en, dec_us, we, busy, done;
  logic [3:0] nbytes;

  jtkcpu_pshpul dut (
`ifdef JTKCPU_PSHPUL_WAIT_EN
    .mem_wait  (mem_wait),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .start     (start),
    .pull      (pull),
    .ussel     (ussel),
    .mask      (mask),
    .psh_sel   (psh_sel),
    .psh_hilon (psh_hilon),
    .psh_ussel (psh_ussel),
    .pul_en    (pul_en),
    .dec_us    (dec_us),
    .we        (we),
    .busy      (busy),
    .done      (done),
    .nbytes    (nbytes)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: a sequence is the list of (register, high-byte) transfers still to go
  typedef struct {
    int   b;
    logic h;
  } xb_t;

  xb_t  q[$];
  bit   m_done;
  int   m_nb;
  bit   m_us;
  bit   m_pull;
  logic wait_now;

`ifdef JTKCPU_PSHPUL_WAIT_EN
  always_comb wait_now = mem_wait;
`else
  assign wait_now = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done = 0;
      m_nb   = 0;
      m_us   = 0;
      m_pull = 0;
    end else if (cen) begin
      if (m_done) begin
        m_done = 0;
      end else if (q.size() > 0) begin
        if (!wait_now) begin
          q.delete(0);
          m_nb++;
          if (q.size() == 0) m_done = 1;
        end
      end else if (start) begin
        m_pull = pull;
        m_us   = ussel;
        m_nb   = 0;
        if (!pull) begin
          for (int b = 7; b >= 0; b--) begin
            if (mask[b]) begin
              q.push_back('{b, 1'b0});
              if (b >= 4) q.push_back('{b, 1'b1});
            end
          end
        end else begin
          for (int b = 0; b < 8; b++) begin
            if (mask[b]) begin
              if (b >= 4) q.push_back('{b, 1'b1});
              q.push_back('{b, 1'b0});
            end
          end
        end
        if (q.size() == 0) m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_sel;
    logic       e_h, x;
    x     = (q.size() > 0);
    e_sel = x ? (8'd1 << q[0].b) : 8'd0;
    e_h   = x ? q[0].h : 1'b0;
    chk("m_sel",   psh_sel,   e_sel);
    chk("m_hilon", psh_hilon, e_h);
    chk("m_pul",   pul_en,    x && m_pull);
    chk("m_dec",   dec_us,    x && !m_pull);
    chk("m_we",    we,        x && !m_pull);
    chk("m_busy",  busy,      x || m_done);
    chk("m_done",  done,      m_done);
    chk("m_nb",    nbytes,    m_nb);
    chk("m_us",    psh_ussel, m_us);
  end

  logic [7:0] ff_sel[12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h10,
                             8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80};
  logic       ff_h[12]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    cen = 1; start = 0; pull = 0; ussel = 0; mask = 0; mem_wait = 0;
    #2 rst_n = 0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_sel", psh_sel, 0);
    chk("rst_nb", nbytes, 0);
    rst_n = 1;
    cyc();

    // push PC then CC
    mask = 8'h81; pull = 0; ussel = 0; start = 1;
    cyc(); start = 0;
    chk("p81_sel0", psh_sel, 8'h80); chk("p81_h0", psh_hilon, 0); chk("p81_we0", we, 1);
    cyc();
    chk("p81_sel1", psh_sel, 8'h80); chk("p81_h1", psh_hilon, 1); chk("p81_dec1", dec_us, 1);
    cyc();
    chk("p81_sel2", psh_sel, 8'h01); chk("p81_h2", psh_hilon, 0); chk("p81_we2", we, 1);
    cyc();
    chk("p81_done", done, 1); chk("p81_nb", nbytes, 3); chk("p81_sel3", psh_sel, 0);
    cyc();
    chk("p81_idle", busy, 0); chk("p81_done_end", done, 0);

    // pull everything from U stack
    mask = 8'hFF; pull = 1; ussel = 1; start = 1;
    cyc(); start = 0;
    for (int i = 0; i < 12; i++) begin
      chk("pFF_sel", psh_sel, ff_sel[i]);
      chk("pFF_h", psh_hilon, ff_h[i]);
      chk("pFF_pul", pul_en, 1);
      chk("pFF_we", we, 0);
      cyc();
    end
    chk("pFF_done", done, 1); chk("pFF_nb", nbytes, 12); chk("pFF_us", psh_ussel, 1);
    cyc();

    // empty mask
    mask = 8'h00; pull = 0; ussel = 0; start = 1;
    cyc(); start = 0;
    chk("p00_done", done, 1); chk("p00_busy", busy, 1); chk("p00_dec", dec_us, 0);
    chk("p00_pul", pul_en, 0); chk("p00_nb", nbytes, 0);
    cyc();
    chk("p00_idle", busy, 0);

    // reset mid push
    mask = 8'h30; pull = 0; start = 1;
    cyc(); start = 0;
    cyc(); cyc();
    chk("p30_sel", psh_sel, 8'h10); chk("p30_nb2", nbytes, 2);
    rst_n = 0; #1;
    chk("r_sel", psh_sel, 0); chk("r_busy", busy, 0); chk("r_we", we, 0);
    chk("r_dec", dec_us, 0); chk("r_nb", nbytes, 0); chk("r_done", done, 0);
    chk("r_h", psh_hilon, 0);
    cyc(); rst_n = 1; cyc();
    start = 1;
    cyc(); start = 0;
    chk("p30b_sel", psh_sel, 8'h20);
    repeat (4) cyc();
    chk("p30b_done", done, 1); chk("p30b_nb", nbytes, 4);
    cyc();

    // clock-enable gaps, start while busy ignored
    mask = 8'h06; pull = 1; ussel = 0; start = 1;
    cyc();
    mask = 8'hFF; cen = 0;
    cyc();
    chk("c_sel0", psh_sel, 8'h02); chk("c_pul0", pul_en, 1); chk("c_nb0", nbytes, 0);
    cen = 1; cyc();
    chk("c_sel1", psh_sel, 8'h04); chk("c_nb1", nbytes, 1);
    cen = 0; cyc();
    chk("c_sel1h", psh_sel, 8'h04); chk("c_nb1h", nbytes, 1); chk("c_pul1h", pul_en, 1);
    cen = 1; start = 0; cyc();
    chk("c_done", done, 1); chk("c_nb2", nbytes, 2);
    cyc();
    chk("c_idle", busy, 0);

`ifdef JTKCPU_PSHPUL_WAIT_EN
    mask = 8'h10; pull = 0; start = 1;
    cyc(); start = 0;
    chk("w_sel0", psh_sel, 8'h10); chk("w_h0", psh_hilon, 0);
    cyc();
    mem_wait = 1;
    chk("w_h1", psh_hilon, 1);
    cyc(); cyc();
    chk("w_sel_hold", psh_sel, 8'h10); chk("w_h_hold", psh_hilon, 1);
    chk("w_nb_hold", nbytes, 1); chk("w_we_hold", we, 1);
    mem_wait = 0;
    cyc();
    chk("w_done", done, 1); chk("w_nb", nbytes, 2);
    cyc();
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cen   = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 2) == 0);
      pull  = 1'($urandom_range(0, 1));
      ussel = 1'($urandom_range(0, 1));
      mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
`ifdef JTKCPU_PSHPUL_WAIT_EN
      mem_wait = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        cyc();
        rst_n = 1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
